// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch-PC register with a direct-mapped branch target buffer.
// The BTB predicts the next fetch PC from CurrentPC, and is trained by the
// execute stage's resolution port. A mispredict redirects fetch (Flush) and
// overrides any stall.
module pc_fetch_unit #(
  parameter int unsigned       ADDR_W      = 64,
  parameter int unsigned       BTB_ENTRIES = 16,
  parameter int unsigned       INST_BYTES  = 4,
  parameter int unsigned       IMM_SHIFT   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              Stall,
  output logic [ADDR_W-1:0] CurrentPC,
  output logic [ADDR_W-1:0] NextPC,
  output logic              PredTaken,
  input  logic              ResValid,
  input  logic [ADDR_W-1:0] ResPC,
  input  logic [ADDR_W-1:0] ResSignExtImm64,
  input  logic              ResBranch,
  input  logic              ResUncondbranch,
  input  logic              ResALUZero,
  input  logic              ResPredTaken,
  input  logic [ADDR_W-1:0] ResPredNextPC,
  output logic              Flush,
  output logic [31:0]       MispredictCount
);

  localparam int unsigned IDX_W   = (BTB_ENTRIES > 1) ? $clog2(BTB_ENTRIES) : 1;
  localparam int unsigned TAG_LSB = IMM_SHIFT + IDX_W;
  localparam int unsigned TAG_W   = ADDR_W - TAG_LSB;
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(INST_BYTES);

  // Architectural state
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       mispredict_cnt_q, mispredict_cnt_d;

  // Flattened BTB views, one slice driven by each entry below
  logic [BTB_ENTRIES-1:0]             valid_vec;
  logic [BTB_ENTRIES-1:0][1:0]        ctr_vec;
  logic [BTB_ENTRIES-1:0][TAG_W-1:0]  tag_vec;
  logic [BTB_ENTRIES-1:0][ADDR_W-1:0] tgt_vec;

  // Fetch-side lookup (sees pre-update BTB contents in an update cycle)
  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic             fetch_hit;

  assign fetch_idx = pc_q[IMM_SHIFT +: IDX_W];
  assign fetch_tag = pc_q[ADDR_W-1:TAG_LSB];
  assign fetch_hit = valid_vec[fetch_idx] && (tag_vec[fetch_idx] == fetch_tag);
  assign PredTaken = fetch_hit && ctr_vec[fetch_idx][1];
  assign NextPC    = PredTaken ? tgt_vec[fetch_idx] : pc_q + INC;
  assign CurrentPC = pc_q;

  // Resolution: actual outcome versus the prediction issued for ResPC
  logic [IDX_W-1:0]  res_idx;
  logic [TAG_W-1:0]  res_tag;
  logic              res_hit;
  logic              res_taken;
  logic [ADDR_W-1:0] res_target;
  logic [ADDR_W-1:0] res_correct;
  logic              mispredict;

  assign res_idx     = ResPC[IMM_SHIFT +: IDX_W];
  assign res_tag     = ResPC[ADDR_W-1:TAG_LSB];
  assign res_hit     = valid_vec[res_idx] && (tag_vec[res_idx] == res_tag);
  assign res_taken   = ResUncondbranch || (ResBranch && ResALUZero);
  assign res_target  = ResPC + (ResSignExtImm64 << IMM_SHIFT);
  assign res_correct = res_taken ? res_target : ResPC + INC;
  assign mispredict  = ResValid &&
                       ((ResPredTaken != res_taken) || (ResPredNextPC != res_correct));
  assign Flush       = mispredict;
  assign MispredictCount = mispredict_cnt_q;

  // BTB write controls for the entry addressed by ResPC
  logic       upd_en;      // valid/counter write
  logic       upd_valid;
  logic [1:0] upd_ctr;
  logic       upd_fields;  // tag/target write
  logic [1:0] cur_ctr;

  assign cur_ctr = ctr_vec[res_idx];

  // Decide the BTB update from hit/miss and branch kind
  always_comb begin
    upd_en     = 1'b0;
    upd_valid  = 1'b0;
    upd_ctr    = cur_ctr;
    upd_fields = 1'b0;
    if (ResValid) begin
      if (res_hit) begin
        if (ResUncondbranch) begin
          upd_en     = 1'b1;
          upd_valid  = 1'b1;
          upd_ctr    = 2'd3;
          upd_fields = 1'b1;
        end else if (ResBranch) begin
          upd_en     = 1'b1;
          upd_valid  = 1'b1;
          upd_fields = 1'b1;
          if (ResALUZero) upd_ctr = (cur_ctr == 2'd3) ? 2'd3 : cur_ctr + 2'd1;
          else            upd_ctr = (cur_ctr == 2'd0) ? 2'd0 : cur_ctr - 2'd1;
        end else begin
          // A non-branch hit means the entry aliases a different instruction
          upd_en    = 1'b1;
          upd_valid = 1'b0;
        end
      end else if (res_taken) begin
        upd_en     = 1'b1;
        upd_valid  = 1'b1;
        upd_ctr    = ResUncondbranch ? 2'd3 : 2'd2;
        upd_fields = 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_entry
      logic              sel;
      logic              valid_q;
      logic [1:0]        ctr_q;
      logic [TAG_W-1:0]  tag_q;
      logic [ADDR_W-1:0] tgt_q;

      assign sel = (res_idx == IDX_W'(gi));

      // Valid bit and 2-bit counter: cleared by reset, trained on resolution
      always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
          valid_q <= 1'b0;
          ctr_q   <= 2'd0;
        end else if (upd_en && sel) begin
          valid_q <= upd_valid;
          ctr_q   <= upd_ctr;
        end
      end

      // Tag and target carry no reset; they are only meaningful when valid
      always_ff @(posedge CLK) begin
        if (upd_fields && sel) begin
          tag_q <= res_tag;
          tgt_q <= res_target;
        end
      end

      assign valid_vec[gi] = valid_q;
      assign ctr_vec[gi]   = ctr_q;
      assign tag_vec[gi]   = tag_q;
      assign tgt_vec[gi]   = tgt_q;
    end
  endgenerate

  // Next PC: redirect beats stall, stall beats prediction
  always_comb begin
    pc_d = NextPC;
    if (mispredict)  pc_d = res_correct;
    else if (Stall)  pc_d = pc_q;
  end

  // Saturating mispredict counter next value
  always_comb begin
    mispredict_cnt_d = mispredict_cnt_q;
    if (mispredict && (mispredict_cnt_q != 32'hFFFF_FFFF))
      mispredict_cnt_d = mispredict_cnt_q + 32'd1;
  end

  // Fetch PC and mispredict counter registers
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      pc_q             <= RESET_PC;
      mispredict_cnt_q <= 32'd0;
    end else begin
      pc_q             <= pc_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios followed by random resolution
// traffic, all checked against a behavioural BTB/PC model.
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset_L = 1'b0;
  logic        Stall = 1'b0;
  logic [63:0] CurrentPC, NextPC;
  logic        PredTaken;
  logic        ResValid = 1'b0;
  logic [63:0] ResPC = '0, ResSignExtImm64 = '0, ResPredNextPC = '0;
  logic        ResBranch = 1'b0, ResUncondbranch = 1'b0, ResALUZero = 1'b0, ResPredTaken = 1'b0;
  logic        Flush;
  logic [31:0] MispredictCount;

  pc_fetch_unit dut (
    .CLK(CLK), .Reset_L(Reset_L), .Stall(Stall),
    .CurrentPC(CurrentPC), .NextPC(NextPC), .PredTaken(PredTaken),
    .ResValid(ResValid), .ResPC(ResPC), .ResSignExtImm64(ResSignExtImm64),
    .ResBranch(ResBranch), .ResUncondbranch(ResUncondbranch), .ResALUZero(ResALUZero),
    .ResPredTaken(ResPredTaken), .ResPredNextPC(ResPredNextPC),
    .Flush(Flush), .MispredictCount(MispredictCount)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: 16-entry direct-mapped table, 4-byte instructions, imm << 2
  logic        m_valid [16];
  logic [63:0] m_tag   [16];
  logic [63:0] m_tgt   [16];
  int          m_ctr   [16];
  logic [63:0] m_pc;
  logic [31:0] m_cnt;

  // Outputs observed during the most recent step
  logic        last_flush, last_pt;
  logic [63:0] last_np;

  function automatic int idx_of(input logic [63:0] pc);
    return int'((pc >> 2) & 64'hF);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = 64'h0;
    m_cnt = 32'h0;
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 0;
    end
  endtask

  task automatic predict(input logic [63:0] pc, output logic pt, output logic [63:0] np);
    int   i;
    logic hit;
    i   = idx_of(pc);
    hit = m_valid[i] && (m_tag[i] == (pc >> 6));
    pt  = hit && (m_ctr[i] >= 2);
    np  = pt ? m_tgt[i] : pc + 64'd4;
  endtask

  // Apply one cycle of inputs, check combinational outputs, clock, check state
  task automatic step(input logic st, input logic rv, input logic [63:0] rpc,
                      input logic [63:0] imm, input logic br, input logic ub,
                      input logic z, input logic rpt, input logic [63:0] rpn);
    logic        pt, t, m, hit;
    logic [63:0] np, a, c;
    int          i;
    Stall = st; ResValid = rv; ResPC = rpc; ResSignExtImm64 = imm;
    ResBranch = br; ResUncondbranch = ub; ResALUZero = z;
    ResPredTaken = rpt; ResPredNextPC = rpn;
    #1;
    predict(m_pc, pt, np);
    t = ub || (br && z);
    a = rpc + (imm << 2);
    c = t ? a : rpc + 64'd4;
    m = rv && ((rpt != t) || (rpn != c));
    last_flush = Flush; last_pt = PredTaken; last_np = NextPC;
    chk("PredTaken", {63'b0, PredTaken}, {63'b0, pt});
    chk("NextPC", NextPC, np);
    chk("Flush", {63'b0, Flush}, {63'b0, m});
    @(posedge CLK);
    if (m)        m_pc = c;
    else if (!st) m_pc = np;
    if (m && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    if (rv) begin
      i   = idx_of(rpc);
      hit = m_valid[i] && (m_tag[i] == (rpc >> 6));
      if (hit) begin
        if (ub) begin
          m_ctr[i] = 3; m_tgt[i] = a;
        end else if (br) begin
          m_ctr[i] = z ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
          m_tgt[i] = a;
        end else begin
          m_valid[i] = 1'b0;
        end
      end else if (t) begin
        m_valid[i] = 1'b1; m_tag[i] = rpc >> 6; m_tgt[i] = a; m_ctr[i] = ub ? 3 : 2;
      end
    end
    #1;
    chk("CurrentPC", CurrentPC, m_pc);
    chk("MispredictCount", {32'b0, MispredictCount}, {32'b0, m_cnt});
    @(negedge CLK);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  // Mispredicted non-branch at 0xC: redirects fetch to 0x10
  task automatic redirect_to_10();
    step(1'b0, 1'b1, 64'hC, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
  endtask

  initial begin
    logic        st, rv, br, ub, z, rpt, pt_r, t_r;
    logic [63:0] rpc, imm, rpn, np_r;
    int          s, kind, mode;

    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_pc", CurrentPC, 64'h0);
    chk("rst_np", NextPC, 64'h4);
    chk("rst_pt", {63'b0, PredTaken}, 64'h0);
    chk("rst_cnt", {32'b0, MispredictCount}, 64'h0);
    @(negedge CLK);
    Reset_L = 1'b1;

    // Sequential fetch from reset
    repeat (3) idle();
    chk("seq_pc", CurrentPC, 64'hC);

    // Taken conditional branch predicted not-taken: allocate + redirect
    step(1'b0, 1'b1, 64'h10, 64'd3, 1'b1, 1'b0, 1'b1, 1'b0, 64'h14);
    chk("alloc_flush", {63'b0, last_flush}, 64'h1);
    chk("alloc_pc", CurrentPC, 64'h1C);
    chk("alloc_cnt", {32'b0, MispredictCount}, 64'h1);
    redirect_to_10();
    chk("redir_pc", CurrentPC, 64'h10);
    idle();
    chk("hit_pt", {63'b0, last_pt}, 64'h1);
    chk("hit_np", last_np, 64'h1C);

    // Two correctly predicted not-taken resolutions: counter 2 -> 1 -> 0
    repeat (2) begin
      step(1'b0, 1'b1, 64'h10, 64'd3, 1'b1, 1'b0, 1'b0, 1'b0, 64'h14);
      chk("nt_flush", {63'b0, last_flush}, 64'h0);
    end
    redirect_to_10();
    idle();
    chk("nt_pt", {63'b0, last_pt}, 64'h0);
    chk("nt_np", last_np, 64'h14);

    // One taken resolution from counter 0 stays weakly not-taken; a second predicts taken
    step(1'b0, 1'b1, 64'h10, 64'd3, 1'b1, 1'b0, 1'b1, 1'b0, 64'h14);
    redirect_to_10();
    idle();
    chk("ctr1_pt", {63'b0, last_pt}, 64'h0);
    step(1'b0, 1'b1, 64'h10, 64'd3, 1'b1, 1'b0, 1'b1, 1'b0, 64'h14);
    redirect_to_10();
    idle();
    chk("ctr2_pt", {63'b0, last_pt}, 64'h1);

    // Alias: non-branch hit invalidates the entry
    step(1'b0, 1'b1, 64'h10, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h1C);
    chk("alias_flush", {63'b0, last_flush}, 64'h1);
    chk("alias_pc", CurrentPC, 64'h14);
    redirect_to_10();
    idle();
    chk("alias_pt", {63'b0, last_pt}, 64'h0);
    chk("alias_np", last_np, 64'h14);

    // Mispredict overrides stall; plain stall holds
    step(1'b1, 1'b1, 64'h40, -64'sd4, 1'b0, 1'b1, 1'b0, 1'b0, 64'h44);
    chk("stall_redir_pc", CurrentPC, 64'h30);
    step(1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    chk("stall_hold_pc", CurrentPC, 64'h30);

    // Counter saturation
    force dut.mispredict_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.mispredict_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    redirect_to_10();
    chk("sat_cnt", {32'b0, MispredictCount}, 64'hFFFF_FFFF);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      st = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 4))
        0: rpc = 64'h10;
        1: rpc = 64'h410;
        2: rpc = 64'h40;
        3: rpc = m_pc;
        default: rpc = {$urandom, $urandom} & ~64'h3;
      endcase
      kind = int'($urandom_range(0, 2));
      br = (kind == 1);
      ub = (kind == 2);
      z  = $urandom_range(0, 1) == 1;
      s  = int'($urandom_range(0, 32)) - 16;
      imm = 64'(signed'(s));
      mode = int'($urandom_range(0, 2));
      t_r = ub || (br && z);
      if (mode == 0) begin
        rpt = t_r;
        rpn = t_r ? rpc + (imm << 2) : rpc + 64'd4;
      end else if (mode == 1) begin
        predict(rpc, pt_r, np_r);
        rpt = pt_r;
        rpn = np_r;
      end else begin
        rpt = $urandom_range(0, 1) == 1;
        rpn = rpc + 64'd4;
      end
      step(st, rv, rpc, imm, br, ub, z, rpt, rpn);
    end

    // Asynchronous reset mid-cycle
    Stall = 1'b0; ResValid = 1'b0;
    @(posedge CLK);
    #2;
    Reset_L = 1'b0;
    #1;
    chk("arst_pc", CurrentPC, 64'h0);
    chk("arst_np", NextPC, 64'h4);
    chk("arst_pt", {63'b0, PredTaken}, 64'h0);
    chk("arst_cnt", {32'b0, MispredictCount}, 64'h0);
    chk("arst_flush", {63'b0, Flush}, 64'h0);
    model_reset();
    @(negedge CLK);
    Reset_L = 1'b1;
    idle();
    chk("post_rst_pc", CurrentPC, 64'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 64: PC, immediate and target width.
REQ-002 Parameter BTB_ENTRIES, default 16: branch-target-buffer entries; power of two, 2..256.
REQ-003 Parameter INST_BYTES, default 4: sequential PC increment.
REQ-004 Parameter IMM_SHIFT, default 2: left shift applied to the branch immediate.
REQ-005 Parameter RESET_PC, default 0: PC value after reset.
REQ-006 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-007 Reset_L  in  1  asynchronous, active-low reset.
REQ-008 Stall  in  1  hold the current PC (fetch back-pressure).
REQ-009 CurrentPC  out  ADDR_W  registered fetch PC.
REQ-010 NextPC  out  ADDR_W  combinational predicted next fetch PC.
REQ-011 PredTaken  out  1  combinational; BTB predicts CurrentPC taken.
REQ-012 ResValid  in  1  execute stage is resolving one instruction this cycle.
REQ-013 ResPC  in  ADDR_W  PC of the resolving instruction.
REQ-014 ResSignExtImm64  in  ADDR_W  sign-extended branch immediate.
REQ-015 ResBranch / ResUncondbranch / ResALUZero  in  1 each  conditional-branch flag, unconditional-branch flag, ALU zero result.
REQ-016 ResPredTaken  in  1 and ResPredNextPC  in  ADDR_W  prediction originally issued for ResPC.
REQ-017 Flush  out  1  combinational; asserted in the mispredict cycle.
REQ-018 MispredictCount  out  32  registered count of mispredicts.

Function
REQ-019 Index = CurrentPC[IMM_SHIFT +: log2(BTB_ENTRIES)]; tag = all bits above the index field; each entry holds valid, tag, target and a 2-bit counter.
REQ-020 Hit = valid and tag match; PredTaken = Hit and counter[1]; NextPC = PredTaken ? entry target : CurrentPC + INST_BYTES (modulo 2^ADDR_W).
REQ-021 Actual taken T = ResUncondbranch or (ResBranch and ResALUZero); actual target A = ResPC + (ResSignExtImm64 << IMM_SHIFT), truncated to ADDR_W; correct next C = T ? A : ResPC + INST_BYTES.
REQ-022 Mispredict M = ResValid and (ResPredTaken != T or ResPredNextPC != C); Flush = M in the same cycle.
REQ-023 PC update priority: M -> CurrentPC <= C, regardless of Stall; else Stall -> hold; else CurrentPC <= NextPC.
REQ-024 BTB update applies only when ResValid=1, using ResPC's index/tag, at the clock edge.
REQ-025 On a hit with a conditional branch: counter saturating +1 if T, -1 if not T (range 0..3); target <= A.
REQ-026 On a hit with an unconditional branch: counter <= 3; target <= A.
REQ-027 On a miss with T=1: allocate (overwrite) the entry; valid=1, tag, target=A, counter=3 if unconditional else 2.
REQ-028 On a miss with T=0: no change.
REQ-029 A hit where ResBranch=0 and ResUncondbranch=0 (alias) invalidates the entry.
REQ-030 Same-cycle lookup and update of the same entry: the lookup sees the pre-update contents.
REQ-031 MispredictCount increments by 1 per cycle with M=1 and saturates at 0xFFFFFFFF.

Reset
REQ-032 While Reset_L=0, asynchronously: CurrentPC = RESET_PC; all valid bits = 0; counters = 0; MispredictCount = 0.
REQ-033 Tags and targets need not be reset.
REQ-034 Out of reset: NextPC = RESET_PC + INST_BYTES; PredTaken = 0; Flush follows REQ-022.
REQ-035 Reset asserted mid-operation discards any in-flight update; the first edge after release performs a normal REQ-023 update.

Verification
REQ-036 Reset release, Stall=0, ResValid=0, 3 clocks -> CurrentPC goes 0x0, 0x4, 0x8, 0xC; PredTaken=0 throughout.
REQ-037 Resolve ResPC=0x10, ResBranch=1, ResALUZero=1, Imm=3, ResPredTaken=0, ResPredNextPC=0x14 -> Flush=1, next CurrentPC=0x1C, MispredictCount=1, entry 4 valid with counter=2; a later fetch at 0x10 gives PredTaken=1 and NextPC=0x1C.
REQ-038 Same branch resolved not-taken twice with correct predictions issued -> counter goes 2 -> 1 -> 0; fetch at 0x10 gives PredTaken=0 and NextPC=0x14; no Flush.
REQ-039 Stall=1 with mispredict (ResPC=0x40, ResUncondbranch=1, Imm=-4, ResPredTaken=0) -> CurrentPC=0x30 despite Stall; with Stall=1 and no mispredict, CurrentPC holds.
REQ-040 Alias: entry valid for 0x10, resolve ResPC=0x10 as non-branch with ResPredTaken=1 -> Flush=1, CurrentPC=0x14, entry invalidated.
REQ-041 Force MispredictCount to 0xFFFFFFFF, then mispredict -> count stays 0xFFFFFFFF; assert Reset_L=0 asynchronously mid-cycle -> outputs take reset values immediately.
